seg_scan_driver: RTL and testbench

- Six-digit common-anode seven-segment scan driver; sits directly downstream of the HH:MM:SS time counter.
- Consumes that counter's data/point/en/sign bus and converts the 20-bit binary value to BCD with a sequential double-dabble engine.
- Time-multiplexes the six digits with leading-zero blanking, decimal points and a minus sign.

---
 rtl/seg_scan_driver.sv | 187 ++++++++++++++++++
 tb/tb_seg_scan_driver.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - six-digit seven-segment scan driver with sequential BCD conversion (optional LEADING_ZERO_BLANK_EN)
module seg_scan_driver #(
    parameter int SCAN_DIV = 50000,
    parameter int MAX_VAL  = 999999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] data,
    input  logic [5:0]  point,
    input  logic        en,
    input  logic        sign,
    output logic [5:0]  seg_sel,
    output logic [7:0]  seg_led
);

    localparam int          DW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [19:0] MAX_V    = 20'(MAX_VAL);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [4:0]  bit_cnt;
    logic [19:0] bin_sh;
    logic [23:0] bcd_sh;
    logic [23:0] bcd_adj;
    logic [5:0]  point_sh;
    logic        sign_sh;
    logic        en_sh;

    logic [23:0] dig_q;
    logic [5:0]  point_q;
    logic        sign_q;
    logic        en_q;

    logic [DW-1:0] div_cnt;
    logic [2:0]    idx;
    logic [3:0]    nib;
    logic [7:0]    code;

    function automatic logic [7:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    // Converter state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Converter next state: one sample cycle, 20 shift cycles, one commit cycle
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = S_SHIFT;
            S_SHIFT: if (bit_cnt == 5'd19) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Double-dabble correction: add 3 to every nibble that would overflow on the shift
    always_comb begin
        bcd_adj = bcd_sh;
        for (int i = 0; i < 6; i++) begin
            if (bcd_sh[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_sh[i*4 +: 4] + 4'd3;
        end
    end

    // Converter datapath: shadow sampling, shifting, and atomic commit to display registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= '0;
            bin_sh   <= '0;
            bcd_sh   <= '0;
            point_sh <= '0;
            sign_sh  <= 1'b0;
            en_sh    <= 1'b0;
            dig_q    <= '0;
            point_q  <= '0;
            sign_q   <= 1'b0;
            en_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    bin_sh   <= (data > MAX_V) ? MAX_V : data;
                    bcd_sh   <= '0;
                    bit_cnt  <= '0;
                    point_sh <= point;
                    sign_sh  <= sign;
                    en_sh    <= en;
                end
                S_SHIFT: begin
                    bcd_sh  <= {bcd_adj[22:0], bin_sh[19]};
                    bin_sh  <= {bin_sh[18:0], 1'b0};
                    bit_cnt <= bit_cnt + 5'd1;
                end
                S_DONE: begin
                    dig_q   <= bcd_sh;
                    point_q <= point_sh;
                    sign_q  <= sign_sh;
                    en_q    <= en_sh;
                end
                default: ;
            endcase
        end
    end

    // Scan divider and digit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            idx     <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    assign nib = dig_q[{idx, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    logic [2:0] h;
    logic [2:0] p;
    logic [2:0] m;

    // Highest significant digit, highest lit point, and the blanking boundary
    always_comb begin
        h = 3'd0;
        p = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (dig_q[i*4 +: 4] != 4'd0) h = 3'(i);
            if (point_q[i])              p = 3'(i);
        end
        m = (h > p) ? h : p;
    end

    // Digit code with leading blanks and a minus just above the most significant digit
    always_comb begin
        code = seg7(nib);
        if (idx > m) begin
            if (sign_q && (idx == m + 3'd1)) code = 8'hBF;
            else                             code = 8'hFF;
        end
    end
`else
    // Digit code with leading zeros shown; sign takes over the leftmost digit
    always_comb begin
        code = seg7(nib);
        if (sign_q && (idx == 3'd5)) code = 8'hBF;
    end
`endif

    // Registered digit select and segment outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_sel <= 6'h3F;
            seg_led <= 8'hFF;
        end else if (en_q) begin
            seg_sel <= ~(6'b000001 << idx);
            seg_led <= {~point_q[idx], code[6:0]};
        end else begin
            seg_sel <= 6'h3F;
            seg_led <= 8'hFF;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - directed self-checking bench for seg_scan_driver
module tb_seg_scan_driver;

    logic        clk;
    logic        rst;
    logic [19:0] data;
    logic [5:0]  point;
    logic        en;
    logic        sign;
    logic [5:0]  seg_sel;
    logic [7:0]  seg_led;

    int checks   = 0;
    int failures = 0;

    seg_scan_driver #(.SCAN_DIV(4), .MAX_VAL(999999)) dut (
        .clk     (clk),
        .rst     (rst),
        .data    (data),
        .point   (point),
        .en      (en),
        .sign    (sign),
        .seg_sel (seg_sel),
        .seg_led (seg_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Capture one full scan and compare each digit; exp holds digit 5 in the top byte
    task automatic check_digits(input string tag, input logic [47:0] exp);
        logic [7:0] got [6];
        for (int i = 0; i < 6; i++) got[i] = 8'hxx;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            for (int i = 0; i < 6; i++) begin
                if (seg_sel == ~(6'b000001 << i)) got[i] = seg_led;
            end
        end
        for (int i = 0; i < 6; i++)
            chk($sformatf("%s_d%0d", tag, i), {24'd0, got[i]}, {24'd0, exp[i*8 +: 8]});
    endtask

    task automatic apply(input logic [19:0] d, input logic [5:0] pt, input logic s, input logic e);
        data  = d;
        point = pt;
        sign  = s;
        en    = e;
        repeat (50) @(negedge clk);
    endtask

    initial begin
        logic [5:0] exp_sel;
        int         n;
        rst   = 1'b1;
        data  = '0;
        point = '0;
        sign  = 1'b0;
        en    = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_sel", {26'd0, seg_sel}, 32'h3F);
        chk("reset_led", {24'd0, seg_led}, 32'hFF);
        rst = 1'b0;

        // 235959: digits right to left 9,5,9,5,3,2
        apply(20'd235959, 6'b0, 1'b0, 1'b1);
        check_digits("t235959", {8'hA4, 8'hB0, 8'h92, 8'h90, 8'h92, 8'h90});

        // Select rotation and hold length of 4 cycles, including the 5->0 wrap
        n = 0;
        while (seg_sel == 6'h3E && n < 40) begin @(negedge clk); n++; end
        while (seg_sel != 6'h3E && n < 40) begin @(negedge clk); n++; end
        chk("scan_align_timeout", {31'd0, (n >= 40)}, 32'd0);
        for (int k = 0; k < 7; k++) begin
            exp_sel = ~(6'b000001 << (k % 6));
            for (int j = 0; j < 4; j++) begin
                if (k != 0 || j != 0) @(negedge clk);
                chk($sformatf("scan_k%0d_j%0d", k, j), {26'd0, seg_sel}, {26'd0, exp_sel});
            end
        end

        // Zero value
        apply(20'd0, 6'b0, 1'b0, 1'b1);
`ifdef LEADING_ZERO_BLANK_EN
        check_digits("zero", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0});
`else
        check_digits("zero", {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0});
`endif

        // 42 with minus sign and point on digit 1
        apply(20'd42, 6'b000010, 1'b1, 1'b1);
`ifdef LEADING_ZERO_BLANK_EN
        check_digits("neg42", {8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'h19, 8'hA4});
`else
        check_digits("neg42", {8'hBF, 8'hC0, 8'hC0, 8'hC0, 8'h19, 8'hA4});
`endif

        // Over-range value clamps to 999999
        apply(20'hFFFFF, 6'b0, 1'b0, 1'b1);
        check_digits("clamp", {8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90});

        // Reset during conversion with a new value pending
        data = 20'd123456;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_async_sel", {26'd0, seg_sel}, 32'h3F);
        chk("rst_async_led", {24'd0, seg_led}, 32'hFF);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (22) @(negedge clk);
        chk("rst_pre_commit_sel", {26'd0, seg_sel}, 32'h3F);
        @(negedge clk);
        chk("rst_first_sel", {26'd0, seg_sel}, 32'h1F);
        chk("rst_first_led", {24'd0, seg_led}, 32'hF9);
        repeat (2) @(negedge clk);
        chk("rst_idx0_sel", {26'd0, seg_sel}, 32'h3E);
        chk("rst_idx0_led", {24'd0, seg_led}, 32'h82);
        check_digits("t123456", {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82});

        // Disable: dark within 43 cycles and stays dark
        en = 1'b0;
        repeat (44) @(negedge clk);
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("dark_sel_%0d", c), {26'd0, seg_sel}, 32'h3F);
            chk($sformatf("dark_led_%0d", c), {24'd0, seg_led}, 32'hFF);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
